page_walker: RTL and testbench

PAGE_WALKER -- requirements
Module: page_walker

---
 rtl/page_walker_if.sv | 46 ++++
 rtl/page_walker.sv | 167 ++++++++++++++++
 tb/tb_page_walker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/page_walker_if.sv
// Walk request, PTE memory and result signals of the page walker.
// slave is the walker side, master the requester/memory side.
interface page_walker_if #(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = $clog2(NUM_RQ)
);
  logic [NUM_RQ-1:0]       IN_rqValid;
  logic [NUM_RQ-1:0][19:0] IN_rqVpn;
  logic [NUM_RQ-1:0]       OUT_rqReady;
  logic [21:0]             IN_satpPpn;

  logic        OUT_memValid;
  logic [33:0] OUT_memAddr;
  logic        IN_memReady;
  logic        IN_memRespValid;
  logic [31:0] IN_memData;

  logic            OUT_pwValid;
  logic            OUT_pwBusy;
  logic [ID_W-1:0] OUT_pwRqID;
  logic [19:0]     OUT_pwVpn;
  logic [21:0]     OUT_pwPpn;
  logic            OUT_pwIsSuperPage;
  logic [2:0]      OUT_pwRwx;
  logic            OUT_pwUser;
  logic            OUT_pwGlobl;
  logic            OUT_pwPageFault;

  modport slave (
    input  IN_rqValid, IN_rqVpn, IN_satpPpn,
    input  IN_memReady, IN_memRespValid, IN_memData,
    output OUT_rqReady, OUT_memValid, OUT_memAddr,
    output OUT_pwValid, OUT_pwBusy, OUT_pwRqID, OUT_pwVpn,
    output OUT_pwPpn, OUT_pwIsSuperPage, OUT_pwRwx,
    output OUT_pwUser, OUT_pwGlobl, OUT_pwPageFault
  );

  modport master (
    output IN_rqValid, IN_rqVpn, IN_satpPpn,
    output IN_memReady, IN_memRespValid, IN_memData,
    input  OUT_rqReady, OUT_memValid, OUT_memAddr,
    input  OUT_pwValid, OUT_pwBusy, OUT_pwRqID, OUT_pwVpn,
    input  OUT_pwPpn, OUT_pwIsSuperPage, OUT_pwRwx,
    input  OUT_pwUser, OUT_pwGlobl, OUT_pwPageFault
  );
endinterface

// File: rtl/page_walker.sv
// Two-level Sv32 page table walker, fixed-priority request ports,
// one PTE read outstanding, one-cycle result strobe.
module page_walker #(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = $clog2(NUM_RQ)
) (
  input  logic         clk,
  input  logic         rst,
  page_walker_if.slave pw
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP
  } state_e;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  state_e          state_q;
  logic [19:0]     vpn_q;
  logic [ID_W-1:0] id_q;
  logic            glob_q;
  logic            memValid_q;
  logic [33:0]     memAddr_q;
  logic            pwValid_q;
  logic [21:0]     ppn_q;
  logic            sp_q;
  logic [2:0]      rwx_q;
  logic            user_q;
  logic            globl_q;
  logic            fault_q;

  logic [NUM_RQ-1:0] gnt_d;
  logic [ID_W-1:0]   gntId_d;
  logic [19:0]       gntVpn_d;
  logic [33:0]       l1Addr_d;
  logic [33:0]       l0Addr_d;

  pte_t        pte;
  logic        inv_d;
  logic        leaf_d;
  logic        fault_d;
  logic        done_d;
  logic [2:0]  unused_bits;

  // Lowest valid index wins: scan downwards, last hit overwrites.
  always_comb begin
    gnt_d    = '0;
    gntId_d  = '0;
    gntVpn_d = '0;
    for (int i = NUM_RQ - 1; i >= 0; i--) begin
      if (pw.IN_rqValid[i]) begin
        gnt_d    = '0;
        gnt_d[i] = 1'b1;
        gntId_d  = ID_W'(i);
        gntVpn_d = pw.IN_rqVpn[i];
      end
    end
  end

  assign pw.OUT_rqReady =
    (!rst && state_q == IDLE) ? gnt_d : '0;

  assign l1Addr_d = {pw.IN_satpPpn, 12'b0}
                  + {22'b0, gntVpn_d[19:10], 2'b0};

  assign pte         = pte_t'(pw.IN_memData);
  assign unused_bits = {pte.rsw, pte.d};
  assign l0Addr_d    = {pte.ppn, 12'b0}
                     + {22'b0, vpn_q[9:0], 2'b0};

  assign inv_d  = !pte.v || (pte.w && !pte.r);
  assign leaf_d = pte.r || pte.x;

  // L0 non-leaf, missing A and misaligned superpages all fault.
  assign fault_d = inv_d
                || (state_q == L0_WAIT && !leaf_d)
                || (leaf_d && !pte.a)
                || (state_q == L1_WAIT && leaf_d
                    && pte.ppn[9:0] != 10'd0);
  assign done_d  = fault_d || leaf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vpn_q      <= '0;
      id_q       <= '0;
      glob_q     <= 1'b0;
      memValid_q <= 1'b0;
      memAddr_q  <= '0;
      pwValid_q  <= 1'b0;
      ppn_q      <= '0;
      sp_q       <= 1'b0;
      rwx_q      <= '0;
      user_q     <= 1'b0;
      globl_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pwValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|gnt_d) begin
            vpn_q      <= gntVpn_d;
            id_q       <= gntId_d;
            glob_q     <= 1'b0;
            memValid_q <= 1'b1;
            memAddr_q  <= l1Addr_d;
            state_q    <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (pw.IN_memReady) begin
            memValid_q <= 1'b0;
            state_q    <= (state_q == L1_REQ)
                        ? L1_WAIT : L0_WAIT;
          end
        end
        L1_WAIT, L0_WAIT: begin
          if (pw.IN_memRespValid) begin
            if (done_d) begin
              ppn_q     <= fault_d ? '0 : pte.ppn;
              rwx_q     <= fault_d ? '0
                         : {pte.r, pte.w, pte.x};
              user_q    <= !fault_d && pte.u;
              globl_q   <= !fault_d && (pte.g || glob_q);
              sp_q      <= !fault_d && state_q == L1_WAIT;
              fault_q   <= fault_d;
              pwValid_q <= 1'b1;
              state_q   <= RESP;
            end else begin
              glob_q     <= pte.g;
              memValid_q <= 1'b1;
              memAddr_q  <= l0Addr_d;
              state_q    <= L0_REQ;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pw.OUT_memValid      = memValid_q;
  assign pw.OUT_memAddr       = memAddr_q;
  assign pw.OUT_pwValid       = pwValid_q;
  assign pw.OUT_pwBusy        = state_q != IDLE;
  assign pw.OUT_pwRqID        = id_q;
  assign pw.OUT_pwVpn         = vpn_q;
  assign pw.OUT_pwPpn         = ppn_q;
  assign pw.OUT_pwIsSuperPage = sp_q;
  assign pw.OUT_pwRwx         = rwx_q;
  assign pw.OUT_pwUser        = user_q;
  assign pw.OUT_pwGlobl       = globl_q;
  assign pw.OUT_pwPageFault   = fault_q;

endmodule

// File: tb/tb_page_walker.sv
// Scoreboard bench for page_walker: memory model checks PTE
// addresses, monitor compares each result against the queue.
module tb_page_walker;

  typedef struct {
    logic [1:0]  id;
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic        sp;
    logic [2:0]  rwx;
    logic        u;
    logic        g;
    logic        pf;
  } exp_t;

  typedef struct {
    logic [33:0] addr;
    logic [31:0] data;
    int          dly;
  } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pw_seen = 0;
  int   pw_cyc = 0;
  int   acc_cyc = 0;

  exp_t sb[$];
  mem_t mq[$];

  page_walker_if bus();

  page_walker dut (
    .clk (clk),
    .rst (rst),
    .pw  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // PTE memory: accepts when ready, answers dly cycles later.
  initial begin
    int          cnt;
    logic [31:0] pd;
    mem_t        m;
    cnt = 0;
    pd  = '0;
    bus.IN_memRespValid = 1'b0;
    bus.IN_memData      = '0;
    forever begin
      @(negedge clk); #1;
      bus.IN_memRespValid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.IN_memRespValid = 1'b1;
          bus.IN_memData      = pd;
        end
      end
      if (bus.OUT_memValid && bus.IN_memReady) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected", 64'(1), 64'(0));
        end else begin
          m = mq.pop_front();
          chk("mem_addr", 64'(bus.OUT_memAddr), 64'(m.addr));
          pd  = m.data;
          cnt = m.dly;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (bus.OUT_pwValid) begin
        pw_seen++;
        pw_cyc = cyc;
        if (sb.size() == 0) begin
          chk("pw_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rqid", 64'(bus.OUT_pwRqID), 64'(e.id));
          chk("vpn", 64'(bus.OUT_pwVpn), 64'(e.vpn));
          chk("ppn", 64'(bus.OUT_pwPpn), 64'(e.ppn));
          chk("super", 64'(bus.OUT_pwIsSuperPage), 64'(e.sp));
          chk("rwx", 64'(bus.OUT_pwRwx), 64'(e.rwx));
          chk("user", 64'(bus.OUT_pwUser), 64'(e.u));
          chk("globl", 64'(bus.OUT_pwGlobl), 64'(e.g));
          chk("fault", 64'(bus.OUT_pwPageFault), 64'(e.pf));
          chk("busy_resp", 64'(bus.OUT_pwBusy), 64'(1));
        end
        @(negedge clk); #1;
        chk("pw_one_cycle", 64'(bus.OUT_pwValid), 64'(0));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send(int p, logic [19:0] vpn);
    int n;
    n = 0;
    @(negedge clk);
    bus.IN_rqValid[p] = 1'b1;
    bus.IN_rqVpn[p]   = vpn;
    #1;
    while (!bus.OUT_rqReady[p] && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rq_ready", 64'(bus.OUT_rqReady[p]), 64'(1));
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.IN_rqValid[p] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || mq.size() != 0) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    @(negedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    int gaps;
    int n;
    int pw_before;
    bus.IN_rqValid  = '0;
    bus.IN_rqVpn    = '0;
    bus.IN_satpPpn  = 22'h00100;
    bus.IN_memReady = 1'b1;
    #1 rst = 1'b1;
    bus.IN_rqValid = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_memvalid", 64'(bus.OUT_memValid), 64'(0));
    chk("rst_pwvalid", 64'(bus.OUT_pwValid), 64'(0));
    chk("rst_busy", 64'(bus.OUT_pwBusy), 64'(0));
    chk("rst_ready", 64'(bus.OUT_rqReady), 64'(0));
    bus.IN_rqValid = '0;
    @(negedge clk);
    rst = 1'b0;

    // 4 KiB walk from port 1
    mq.push_back('{34'h0_0010_0120, 32'h0800_0001, 1});
    mq.push_back('{34'h0_2000_0D14, 32'h1234_50CF, 1});
    sb.push_back('{2'd1, 20'h12345, 22'h048D14,
                   1'b0, 3'b111, 1'b0, 1'b0, 1'b0});
    send(1, 20'h12345);
    wait_done();
    chk("lat_4k", 64'(pw_cyc - acc_cyc + 1), 64'(6));

    // aligned superpage
    mq.push_back('{34'h0_0010_0004, 32'h2000_00CB, 1});
    sb.push_back('{2'd0, 20'h00400, 22'h080000,
                   1'b1, 3'b101, 1'b0, 1'b0, 1'b0});
    send(0, 20'h00400);
    wait_done();
    chk("lat_super", 64'(pw_cyc - acc_cyc + 1), 64'(4));

    // misaligned superpage
    mq.push_back('{34'h0_0010_0008, 32'h0000_04CF, 1});
    sb.push_back('{2'd2, 20'h00800, 22'h0,
                   1'b0, 3'b000, 1'b0, 1'b0, 1'b1});
    send(2, 20'h00800);
    wait_done();

    // leaf with A clear
    mq.push_back('{34'h0_0010_0004, 32'h2000_000B, 1});
    sb.push_back('{2'd0, 20'h00400, 22'h0,
                   1'b0, 3'b000, 1'b0, 1'b0, 1'b1});
    send(0, 20'h00400);
    wait_done();

    // ports 0 and 2 together; port 2 walk inherits L1 G
    mq.push_back('{34'h0_0010_000C, 32'h2000_00CB, 1});
    mq.push_back('{34'h0_0010_0010, 32'h0800_0021, 1});
    mq.push_back('{34'h0_2000_0014, 32'h00AB_C0D3, 1});
    sb.push_back('{2'd0, 20'h00C00, 22'h080000,
                   1'b1, 3'b101, 1'b0, 1'b0, 1'b0});
    sb.push_back('{2'd2, 20'h01005, 22'h002AF0,
                   1'b0, 3'b100, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    bus.IN_rqValid[0] = 1'b1;
    bus.IN_rqVpn[0]   = 20'h00C00;
    bus.IN_rqValid[2] = 1'b1;
    bus.IN_rqVpn[2]   = 20'h01005;
    #1;
    chk("prio_ready", 64'(bus.OUT_rqReady), 64'(3'b001));
    @(posedge clk); #1;
    bus.IN_rqValid[0] = 1'b0;
    gaps = 0;
    n = 0;
    @(negedge clk); #1;
    while (!bus.OUT_rqReady[2] && n < 100) begin
      if (!bus.OUT_pwBusy) gaps++;
      @(negedge clk); #1;
      n++;
    end
    if (!bus.OUT_pwBusy) gaps++;
    chk("prio_ready2", 64'(bus.OUT_rqReady[2]), 64'(1));
    chk("prio_after_resp", 64'(cyc - pw_cyc), 64'(1));
    @(posedge clk); #1;
    bus.IN_rqValid[2] = 1'b0;
    n = 0;
    while (!bus.OUT_pwValid && n < 100) begin
      @(negedge clk); #1;
      if (!bus.OUT_pwBusy) gaps++;
      n++;
    end
    chk("prio_done", 64'(bus.OUT_pwValid), 64'(1));
    chk("prio_busy_gap", 64'(gaps), 64'(1));
    wait_done();

    // memory stall on L1, then invalid L0 PTE
    bus.IN_memReady = 1'b0;
    mq.push_back('{34'h0_0010_0000, 32'h0800_0001, 1});
    mq.push_back('{34'h0_2000_0000, 32'h0000_0000, 1});
    sb.push_back('{2'd1, 20'h00000, 22'h0,
                   1'b0, 3'b000, 1'b0, 1'b0, 1'b1});
    send(1, 20'h00000);
    repeat (5) begin
      @(negedge clk); #1;
      chk("stall_valid", 64'(bus.OUT_memValid), 64'(1));
      chk("stall_addr", 64'(bus.OUT_memAddr),
          64'(34'h0_0010_0000));
    end
    @(negedge clk);
    bus.IN_memReady = 1'b1;
    wait_done();

    // reset in L0_WAIT, late response must be ignored
    mq.push_back('{34'h0_0010_0120, 32'h0800_0001, 1});
    mq.push_back('{34'h0_2000_0D14, 32'h1234_50CF, 6});
    send(1, 20'h12345);
    repeat (4) @(negedge clk);
    #1;
    chk("l0wait_busy", 64'(bus.OUT_pwBusy), 64'(1));
    chk("l0wait_memvalid", 64'(bus.OUT_memValid), 64'(0));
    pw_before = pw_seen;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.OUT_pwBusy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("midrst_no_result", 64'(pw_seen - pw_before), 64'(0));
    chk("midrst_busy_after", 64'(bus.OUT_pwBusy), 64'(0));

    mq.push_back('{34'h0_0010_0120, 32'h0800_0001, 1});
    mq.push_back('{34'h0_2000_0D14, 32'h1234_50CF, 1});
    sb.push_back('{2'd0, 20'h12345, 22'h048D14,
                   1'b0, 3'b111, 1'b0, 1'b0, 1'b0});
    send(0, 20'h12345);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("mq_empty", 64'(mq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
